mem_arbiter: RTL and testbench

- N-client arbitrated front end for the shared 15-bit-addressed video/program BRAM; successor to the fixed two-port memory controller.
- VGA scan-out keeps absolute priority during active pixel slots (pixel_state < 2).
- In all other cycles, NUM_CLIENTS requestors share one memory port under round-robin arbitration with a req/gnt/rvalid handshake.
- Writes landing in the OUTPUT region are mirrored into a FIFO with a valid/ready interface to the output peripheral.

---
 rtl/mem_arbiter_pkg.sv | 41 ++++
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter_fifo.sv | 63 ++++++
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Memory map and helpers for the shared video/program BRAM.
// Regions are word addresses; OUTPUT writes are mirrored to a peripheral.
package mem_map_pkg;

  localparam int ADDR_TEXT   = 0;
  localparam int SIZE_TEXT   = 4096;
  localparam int ADDR_GLYPH  = 4096;
  localparam int SIZE_GLYPH  = 4096;
  localparam int ADDR_INSTR  = 8192;
  localparam int SIZE_INSTR  = 11264;
  localparam int ADDR_INPUT  = 19456;
  localparam int SIZE_INPUT  = 512;
  localparam int ADDR_OUTPUT = 19968;
  localparam int SIZE_OUTPUT = 512;
  localparam int ADDR_STACK  = 20480;

  typedef enum logic {
    SLOT_VGA,
    SLOT_CLIENT
  } slot_e;

  function automatic int idx_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NUM_CLIENTS_DEF = 2;
  localparam int CLIENT_IDX_W = idx_w(NUM_CLIENTS_DEF);

  function automatic logic in_range(
    logic [31:0] a,
    logic [31:0] lo,
    logic [31:0] hi
  );
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic in_output_region(logic [31:0] a);
    return in_range(a, ADDR_OUTPUT, ADDR_STACK);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side req/gnt/rvalid bus of the memory arbiter.
// Address and write data are packed, client i at [i*W +: W].
interface mem_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16
);
  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        we;
  logic [NUM_CLIENTS*ADDR_W-1:0] addr;
  logic [NUM_CLIENTS*DATA_W-1:0] wdata;
  logic [NUM_CLIENTS-1:0]        gnt;
  logic [NUM_CLIENTS-1:0]        rvalid;
  logic [DATA_W-1:0]             rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter_fifo.sv
// Register-based synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shared BRAM front end: VGA-priority slots, round-robin clients,
// fixed 3-cycle read latency and an OUTPUT-region write mirror FIFO.
module mem_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int OUT_DEPTH   = 8,
  parameter int ADDR_OUTPUT = 19968,
  parameter int ADDR_STACK  = 20480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         pixel_state,
  input  logic [ADDR_W-1:0]  vga_addr,
  output logic [DATA_W-1:0]  vga_rdata,
  output logic               vga_rvalid,
  mem_arbiter_if.slave       cli,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  input  logic [DATA_W-1:0]  mem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [DATA_W-1:0]  out_data
);
  import mem_map_pkg::*;

  localparam int IW = idx_w(NUM_CLIENTS);
  localparam int FW = ADDR_W + DATA_W;

  typedef struct packed {
    logic          valid;
    logic          vga;
    logic [IW-1:0] idx;
  } tag_t;

  slot_e                  slot;
  logic [NUM_CLIENTS-1:0] elig, gnt;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d, win;
  logic                   found, gnt_ok;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_wdata;
  logic                   win_we;
  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [FW-1:0]          fifo_dout;

  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_din_q, mem_din_d;
  tag_t                   tag1_q, tag1_d, tag2_q, tag2_d;
  logic [NUM_CLIENTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   vga_rvalid_q, vga_rvalid_d;
  logic [DATA_W-1:0]      vga_rdata_q, vga_rdata_d;

  function automatic logic out_hit(logic [ADDR_W-1:0] a);
    return in_range(32'(a), ADDR_OUTPUT, ADDR_STACK);
  endfunction

  assign slot = (pixel_state < 2'd2) ? SLOT_VGA : SLOT_CLIENT;

  // A full mirror FIFO only stalls writes that would need to push into it.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig[i] = cli.req[i] &
                ~(cli.we[i] &
                  out_hit(cli.addr[i*ADDR_W +: ADDR_W]) &
                  fifo_full);
    end
  end

  always_comb begin
    int best;
    int d;
    best  = NUM_CLIENTS;
    d     = 0;
    win   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      d = (i - int'(rr_ptr_q) + NUM_CLIENTS) % NUM_CLIENTS;
      if (elig[i] && d < best) begin
        best = d;
        win  = IW'(i);
      end
    end
    found = (best < NUM_CLIENTS);
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win == IW'(i)) begin
        win_addr  = cli.addr[i*ADDR_W +: ADDR_W];
        win_wdata = cli.wdata[i*DATA_W +: DATA_W];
        win_we    = cli.we[i];
      end
    end
  end

  assign gnt_ok = found & (slot == SLOT_CLIENT) & reset;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      gnt[i] = gnt_ok & (win == IW'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_ok) begin
      rr_ptr_d = (win == IW'(NUM_CLIENTS - 1)) ? '0 : win + IW'(1);
    end
  end

  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    tag1_d     = '0;
    unique case (1'b1)
      slot == SLOT_VGA: begin
        mem_addr_d = vga_addr;
        tag1_d     = '{valid: 1'b1, vga: 1'b1, idx: '0};
      end
      gnt_ok: begin
        mem_we_d   = win_we;
        mem_addr_d = win_addr;
        mem_din_d  = win_wdata;
        tag1_d     = '{valid: ~win_we, vga: 1'b0, idx: win};
      end
      default: ;
    endcase
  end

  // Tag stage 2 lines up with mem_dout; the result register adds the third cycle.
  always_comb begin
    tag2_d       = tag1_q;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    vga_rvalid_d = 1'b0;
    vga_rdata_d  = vga_rdata_q;
    if (tag2_q.valid && tag2_q.vga) begin
      vga_rvalid_d = 1'b1;
      vga_rdata_d  = mem_dout;
    end
    if (tag2_q.valid && !tag2_q.vga) begin
      rdata_d = mem_dout;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        rvalid_d[i] = (tag2_q.idx == IW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  assign fifo_push = gnt_ok & win_we & out_hit(win_addr);
  assign fifo_pop  = ~fifo_empty & out_ready;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({win_addr, win_wdata}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign cli.gnt    = gnt;
  assign cli.rvalid = rvalid_q;
  assign cli.rdata  = rdata_q;
  assign vga_rvalid = vga_rvalid_q;
  assign vga_rdata  = vga_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign out_valid  = ~fifo_empty;
  assign {out_addr, out_data} = fifo_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: BRAM model, read/out scoreboards,
// a grant vector table and directed multi-cycle sequences.
module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    pixel_state;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  mem_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) cli ();

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_state (pixel_state),
    .vga_addr    (vga_addr),
    .vga_rdata   (vga_rdata),
    .vga_rvalid  (vga_rvalid),
    .cli         (cli),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bram    [0:32767];
  logic [DW-1:0] ref_mem [0:32767];

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rd_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ow_t;

  rd_t cq[$];
  rd_t vq[$];
  ow_t oq[$];

  // Scoreboard: expectations pushed at grant/VGA slot, popped on rvalid/pop.
  always @(negedge clk) begin
    rd_t e;
    ow_t o;
    logic [AW-1:0] a;
    if (!reset) begin
      cq.delete();
      vq.delete();
      oq.delete();
    end else begin
      if (|cli.rvalid) begin
        if (cq.size() == 0) chk("rvalid_unexpected", 32'(cli.rvalid), 0);
        else begin
          e = cq.pop_front();
          chk("rd_latency", cyc, e.due);
          chk("rd_onehot", 32'(cli.rvalid), 32'(1) << e.idx);
          chk("rd_data", 32'(cli.rdata), 32'(e.data));
        end
      end else if (cq.size() > 0 && cq[0].due <= cyc) begin
        e = cq.pop_front();
        chk("rd_missing", 32'(cli.rvalid), 32'(1) << e.idx);
      end
      if (vga_rvalid) begin
        if (vq.size() == 0) chk("vga_unexpected", 32'(vga_rvalid), 0);
        else begin
          e = vq.pop_front();
          chk("vga_latency", cyc, e.due);
          chk("vga_data", 32'(vga_rdata), 32'(e.data));
        end
      end else if (vq.size() > 0 && vq[0].due <= cyc) begin
        e = vq.pop_front();
        chk("vga_missing", 32'(vga_rvalid), 1);
      end
      if (pixel_state < 2) begin
        chk("gnt_in_vga_slot", 32'(cli.gnt), 0);
        vq.push_back('{cyc + 3, 0, ref_mem[vga_addr]});
      end
      for (int i = 0; i < N; i++) begin
        if (cli.gnt[i]) begin
          a = cli.addr[i*AW +: AW];
          if (cli.we[i]) begin
            ref_mem[a] = cli.wdata[i*DW +: DW];
            if (a >= 15'd19968 && a < 15'd20480)
              oq.push_back('{a, cli.wdata[i*DW +: DW]});
          end else begin
            cq.push_back('{cyc + 3, i, ref_mem[a]});
          end
        end
      end
      if (out_valid && out_ready) begin
        if (oq.size() == 0) chk("out_unexpected", 32'(out_valid), 0);
        else begin
          o = oq.pop_front();
          chk("out_addr", 32'(out_addr), 32'(o.a));
          chk("out_data", 32'(out_data), 32'(o.d));
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_client(int i, logic r, logic w,
                            logic [AW-1:0] a, logic [DW-1:0] d);
    cli.req[i]             = r;
    cli.we[i]              = w;
    cli.addr[i*AW +: AW]   = a;
    cli.wdata[i*DW +: DW]  = d;
  endtask

  typedef struct {
    logic [1:0] ps;
    logic [1:0] req;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t vt[8];

  initial begin
    for (int i = 0; i < 32768; i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end
    bram[15'h0040]    = 16'hBEEF;
    ref_mem[15'h0040] = 16'hBEEF;
    bram[15'h2005]    = 16'h1234;
    ref_mem[15'h2005] = 16'h1234;
    bram[15'h0010]    = 16'h5A5A;
    ref_mem[15'h0010] = 16'h5A5A;

    // Round-robin pointer is 1 when the table starts.
    vt[0] = '{2'd0, 2'b01, 2'b00};
    vt[1] = '{2'd1, 2'b11, 2'b00};
    vt[2] = '{2'd2, 2'b01, 2'b01};
    vt[3] = '{2'd3, 2'b11, 2'b10};
    vt[4] = '{2'd3, 2'b10, 2'b10};
    vt[5] = '{2'd2, 2'b11, 2'b01};
    vt[6] = '{2'd2, 2'b00, 2'b00};
    vt[7] = '{2'd2, 2'b11, 2'b10};

    reset       = 1'b0;
    pixel_state = 2'd2;
    vga_addr    = '0;
    out_ready   = 1'b0;
    set_client(0, 1'b1, 1'b0, 15'h0000, 16'h0);
    set_client(1, 1'b1, 1'b0, 15'h0000, 16'h0);
    repeat (3) @(posedge clk);
    at_neg();
    chk("rst_gnt", 32'(cli.gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_rvalid", 32'(cli.rvalid), 0);
    chk("rst_rdata", 32'(cli.rdata), 0);
    chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
    chk("rst_vga_rdata", 32'(vga_rdata), 0);
    chk("rst_out_valid", 32'(out_valid), 0);

    next(); reset = 1'b1;
    at_neg(); chk("rr_first", 32'(cli.gnt), 32'b01);
    next(); at_neg(); chk("rr_second", 32'(cli.gnt), 32'b10);
    next(); at_neg(); chk("rr_third", 32'(cli.gnt), 32'b01);

    for (int k = 0; k < 8; k++) begin
      next();
      pixel_state = vt[k].ps;
      set_client(0, vt[k].req[0], 1'b0, 15'h2005, 16'h0);
      set_client(1, vt[k].req[1], 1'b0, 15'h0040, 16'h0);
      at_neg();
      chk($sformatf("vec%0d_gnt", k), 32'(cli.gnt), 32'(vt[k].exp_gnt));
    end

    // VGA priority and VGA latency
    next();
    pixel_state = 2'd0;
    vga_addr    = 15'h0040;
    set_client(0, 1'b1, 1'b0, 15'h2005, 16'h0);
    set_client(1, 1'b0, 1'b0, 15'h0000, 16'h0);
    at_neg(); chk("vga_blocks_client", 32'(cli.gnt), 0);
    next(); pixel_state = 2'd2; set_client(0, 1'b0, 1'b0, 15'h0, 16'h0);
    at_neg();
    next(); at_neg(); chk("vga_rvalid_t2", 32'(vga_rvalid), 0);
    next(); at_neg();
    chk("vga_rvalid_t3", 32'(vga_rvalid), 1);
    chk("vga_rdata_t3", 32'(vga_rdata), 32'hBEEF);

    // Client 1 read latency
    next(); set_client(1, 1'b1, 1'b0, 15'h2005, 16'h0);
    at_neg(); chk("c1_read_gnt", 32'(cli.gnt), 32'b10);
    next(); set_client(1, 1'b0, 1'b0, 15'h0, 16'h0);
    at_neg();
    next(); at_neg(); chk("c1_rvalid_t2", 32'(cli.rvalid), 0);
    next(); at_neg();
    chk("c1_rvalid_t3", 32'(cli.rvalid), 32'b10);
    chk("c1_rdata_t3", 32'(cli.rdata), 32'h1234);

    // Output mirror plus memory write-through
    next(); set_client(0, 1'b1, 1'b1, 15'h4E00, 16'hA5A5);
    at_neg(); chk("mirror_gnt", 32'(cli.gnt), 32'b01);
    next(); set_client(0, 1'b0, 1'b0, 15'h0, 16'h0);
    at_neg();
    chk("mirror_valid", 32'(out_valid), 1);
    chk("mirror_addr", 32'(out_addr), 32'h4E00);
    chk("mirror_data", 32'(out_data), 32'hA5A5);
    next(); set_client(0, 1'b1, 1'b0, 15'h4E00, 16'h0);
    at_neg(); chk("readback_gnt", 32'(cli.gnt), 32'b01);
    next(); set_client(0, 1'b0, 1'b0, 15'h0, 16'h0);
    at_neg();
    next(); at_neg();
    next(); at_neg();
    chk("readback_rvalid", 32'(cli.rvalid), 32'b01);
    chk("readback_data", 32'(cli.rdata), 32'hA5A5);
    next(); out_ready = 1'b1;
    at_neg();
    next(); out_ready = 1'b0;
    at_neg(); chk("mirror_drained", 32'(out_valid), 0);

    // Fill the FIFO, then check that only output writes stall
    for (int k = 0; k < 8; k++) begin
      next();
      set_client(0, 1'b1, 1'b1, 15'(15'h4E01 + k), 16'(16'h1000 + k));
      at_neg(); chk($sformatf("fill%0d_gnt", k), 32'(cli.gnt), 32'b01);
    end
    next();
    set_client(0, 1'b1, 1'b1, 15'h4E10, 16'hFFFF);
    set_client(1, 1'b1, 1'b0, 15'h0010, 16'h0);
    at_neg(); chk("full_read_passes", 32'(cli.gnt), 32'b10);
    next(); set_client(1, 1'b0, 1'b0, 15'h0, 16'h0);
    at_neg(); chk("full_write_blocked", 32'(cli.gnt), 0);
    next(); out_ready = 1'b1;
    at_neg(); chk("full_pop_cycle", 32'(cli.gnt), 0);
    next(); out_ready = 1'b0;
    at_neg(); chk("after_pop_gnt", 32'(cli.gnt), 32'b01);
    next(); set_client(0, 1'b0, 1'b0, 15'h0, 16'h0); out_ready = 1'b1;
    repeat (10) begin next(); at_neg(); end
    out_ready = 1'b0;
    chk("full_drained", 32'(out_valid), 0);

    // Reset while a read is in flight
    next(); set_client(0, 1'b1, 1'b1, 15'h4E20, 16'h7777);
    at_neg(); chk("pre_rst_write_gnt", 32'(cli.gnt), 32'b01);
    next(); set_client(0, 1'b1, 1'b0, 15'h2005, 16'h0);
    at_neg(); chk("pre_rst_read_gnt", 32'(cli.gnt), 32'b01);
    next(); reset = 1'b0; set_client(0, 1'b0, 1'b0, 15'h0, 16'h0);
    at_neg(); chk("rst_fifo_empty", 32'(out_valid), 0);
    next(); at_neg();
    next(); reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk($sformatf("post_rst_rvalid%0d", k), 32'(cli.rvalid), 0);
      next();
    end
    at_neg();
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("sb_client_empty", cq.size(), 0);
    chk("sb_vga_empty", vq.size(), 0);
    chk("sb_out_empty", oq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
